// File: rtl/enc_pkg.sv
// Shared encoder-path definitions: symbol type, repacker FSM states and small helpers.
package enc_pkg;

  localparam int unsigned EGF_ORDER   = 8;
  localparam int unsigned ENC_SYM_NUM = 4;

  typedef logic [EGF_ORDER-1:0] sym_t;

  typedef enum logic {
    REP_FILL  = 1'b0,
    REP_FLUSH = 1'b1
  } rep_state_t;

  function automatic int unsigned min_count(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/enc_repacker_shifter.sv
// Combinational buffer update for enc_repacker: drop the popped symbols from the bottom,
// then append the accepted input lanes directly above the surviving contents.
module enc_repacker_shifter
  import enc_pkg::*;
#(
  parameter int unsigned IN_SYM  = ENC_SYM_NUM,
  parameter int unsigned SYM_W   = EGF_ORDER,
  parameter int unsigned BUF_SYM = 2 * ENC_SYM_NUM,
  parameter int unsigned LW      = $clog2(BUF_SYM + 1),
  parameter int unsigned CW_IN   = $clog2(IN_SYM + 1)
) (
  input  logic [BUF_SYM*SYM_W-1:0] mem_q,
  input  logic [LW-1:0]            level,
  input  logic [LW-1:0]            pop,
  input  logic [IN_SYM*SYM_W-1:0]  in_data,
  input  logic [CW_IN-1:0]         in_count,
  output logic [BUF_SYM*SYM_W-1:0] mem_next
);

  int unsigned base;
  int unsigned src;

  always_comb begin
    mem_next = '0;
    base     = 32'(level) - 32'(pop);
    src      = 0;
    for (int unsigned i = 0; i < BUF_SYM; i++) begin
      src = i + 32'(pop);
      if (src < BUF_SYM) begin
        mem_next[i*SYM_W +: SYM_W] = mem_q[src*SYM_W +: SYM_W];
      end
      // in_count is already zero when nothing is pushed, so this window is empty then.
      if ((i >= base) && (i < base + 32'(in_count))) begin
        mem_next[i*SYM_W +: SYM_W] = in_data[(i-base)*SYM_W +: SYM_W];
      end
    end
  end

endmodule

// File: rtl/enc_repacker.sv
// Encoder output symbol repacker: sparse input beats in, dense OUT_SYM beats out, with flush.
// Optional ENC_REPACKER_ZERO_PAD_EN forces out_data lanes at or above out_count to zero.
module enc_repacker
  import enc_pkg::*;
#(
  parameter int unsigned IN_SYM  = ENC_SYM_NUM,
  parameter int unsigned OUT_SYM = ENC_SYM_NUM,
  parameter int unsigned SYM_W   = EGF_ORDER,
  parameter int unsigned BUF_SYM = IN_SYM + OUT_SYM
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(IN_SYM+1)-1:0]  in_count,
  input  logic [IN_SYM*SYM_W-1:0]      in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(OUT_SYM+1)-1:0] out_count,
  output logic [OUT_SYM*SYM_W-1:0]     out_data,
  output logic                         out_last
);

  localparam int unsigned LW     = $clog2(BUF_SYM + 1);
  localparam int unsigned CW_IN  = $clog2(IN_SYM + 1);
  localparam int unsigned CW_OUT = $clog2(OUT_SYM + 1);

  if (BUF_SYM < IN_SYM + OUT_SYM - 1) begin : g_bad_depth
    $error("enc_repacker: BUF_SYM must be at least IN_SYM + OUT_SYM - 1");
  end

  rep_state_t                 state_q, state_d;
  logic [LW-1:0]              level_q, level_d, pop;
  logic [BUF_SYM*SYM_W-1:0]   mem_q, mem_d;
  logic [CW_IN-1:0]           push_cnt;
  logic                       in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REP_FILL;
      level_q <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REP_FILL:  if (in_fire && in_last) state_d = REP_FLUSH;
      REP_FLUSH: if ((out_fire && out_last) || (level_q == '0)) state_d = REP_FILL;
      default:   state_d = REP_FILL;
    endcase
  end

  // out_count reads zero whenever no beat is offered.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_count = '0;
    out_last  = 1'b0;
    case (state_q)
      REP_FILL: begin
        in_ready  = (BUF_SYM - 32'(level_q)) >= IN_SYM;
        out_valid = 32'(level_q) >= OUT_SYM;
        if (out_valid) out_count = CW_OUT'(OUT_SYM);
      end
      REP_FLUSH: begin
        out_valid = level_q != '0;
        out_count = CW_OUT'(min_count(32'(level_q), OUT_SYM));
        out_last  = out_valid && (32'(level_q) <= OUT_SYM);
      end
      default: ;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < OUT_SYM; i++) begin
`ifdef ENC_REPACKER_ZERO_PAD_EN
      if (i < 32'(out_count)) out_data[i*SYM_W +: SYM_W] = mem_q[i*SYM_W +: SYM_W];
`else
      out_data[i*SYM_W +: SYM_W] = mem_q[i*SYM_W +: SYM_W];
`endif
    end
  end

  always_comb begin
    pop      = out_fire ? LW'(out_count) : '0;
    push_cnt = '0;
    if (in_fire) push_cnt = (32'(in_count) > IN_SYM) ? CW_IN'(IN_SYM) : in_count;
    level_d  = level_q - pop + LW'(push_cnt);
  end

  enc_repacker_shifter #(
    .IN_SYM  (IN_SYM),
    .SYM_W   (SYM_W),
    .BUF_SYM (BUF_SYM),
    .LW      (LW),
    .CW_IN   (CW_IN)
  ) u_shifter (
    .mem_q    (mem_q),
    .level    (level_q),
    .pop      (pop),
    .in_data  (in_data),
    .in_count (push_cnt),
    .mem_next (mem_d)
  );

endmodule
